// File: rtl/m2p_gray_counter_ifc.sv
// m2p_gray_counter_ifc
//   Client-side marshaller for the GrayCounterIfc request path. Each accepted
//   method call becomes one 144-bit {tag[15:0], data[127:0]} message, queued
//   in a 2-entry registered FIFO and presented on the outbound pipe. A single
//   outstanding read (readGray/readBin) is tracked by a small FSM. The FSM
//   captures the matching indication and holds the result until it is taken.
//
// Ports
//   CLK, nRST                     clock, asynchronous active-low reset
//   method_<name>__ENA/__RDY      method call handshakes (increment, decrement,
//                                 writeGray, writeBin, readGray, readBin)
//   method_writeGray_v, _writeBin_v  width-bit arguments
//   readResult, readResult__RDY   captured read value and its valid flag
//   resultTake__ENA               consume readResult
//   pipe_enq__ENA/_v/__RDY        outbound message (valid / payload / ready)
//   ind_enq__ENA/_v/__RDY         inbound indication (valid / payload / ready)
//   errCollision, errUnexpected   sticky error flags, cleared only by reset
module m2p_gray_counter_ifc #(
    parameter int width = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              method_increment__ENA,
    output logic              method_increment__RDY,
    input  logic              method_decrement__ENA,
    output logic              method_decrement__RDY,
    input  logic              method_writeGray__ENA,
    input  logic [width-1:0]  method_writeGray_v,
    output logic              method_writeGray__RDY,
    input  logic              method_writeBin__ENA,
    input  logic [width-1:0]  method_writeBin_v,
    output logic              method_writeBin__RDY,
    input  logic              method_readGray__ENA,
    output logic              method_readGray__RDY,
    input  logic              method_readBin__ENA,
    output logic              method_readBin__RDY,
    output logic [width-1:0]  readResult,
    output logic              readResult__RDY,
    input  logic              resultTake__ENA,
    output logic              pipe_enq__ENA,
    output logic [143:0]      pipe_enq_v,
    input  logic              pipe_enq__RDY,
    input  logic              ind_enq__ENA,
    input  logic [143:0]      ind_enq_v,
    output logic              ind_enq__RDY,
    output logic              errCollision,
    output logic              errUnexpected
);

    localparam logic [15:0] TAG_INCREMENT = 16'd0;
    localparam logic [15:0] TAG_DECREMENT = 16'd1;
    localparam logic [15:0] TAG_READ_GRAY = 16'd2;
    localparam logic [15:0] TAG_WRITE_GRAY = 16'd3;
    localparam logic [15:0] TAG_READ_BIN = 16'd4;
    localparam logic [15:0] TAG_WRITE_BIN = 16'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Argument goes in the top data bits, directly below the tag.
    function automatic logic [127:0] place_arg(input logic [width-1:0] v);
        logic [127:0] d;
        d = '0;
        d[127 -: width] = v;
        return d;
    endfunction

    // FIFO state
    logic [143:0] mem [2];
    logic [1:0]   count;
    logic         wr_ptr;
    logic         rd_ptr;
    logic         full;
    logic         empty;

    // Read FSM state
    state_t       state;
    logic [15:0]  exp_tag;
    logic         ind_rdy;

    // Request arbitration
    logic         write_rdy;
    logic         read_rdy;
    logic [5:0]   acc_vec;
    logic         push;
    logic         pop;
    logic         collision;
    logic [15:0]  push_tag;
    logic [127:0] push_data;
    logic         read_issue;
    logic         ind_ok;
    logic         ind_match;
    logic         ind_data_unused;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

    // Ready is a function of registered state only.
    assign write_rdy = !full;
    assign read_rdy  = !full && (state == S_IDLE);

    assign method_increment__RDY = write_rdy;
    assign method_decrement__RDY = write_rdy;
    assign method_writeGray__RDY = write_rdy;
    assign method_writeBin__RDY  = write_rdy;
    assign method_readGray__RDY  = read_rdy;
    assign method_readBin__RDY   = read_rdy;

    // Bit position equals the message tag, so the lowest set bit wins.
    assign acc_vec = {method_writeBin__ENA  && write_rdy,
                      method_readBin__ENA   && read_rdy,
                      method_writeGray__ENA && write_rdy,
                      method_readGray__ENA  && read_rdy,
                      method_decrement__ENA && write_rdy,
                      method_increment__ENA && write_rdy};

    assign push      = |acc_vec;
    assign collision = (acc_vec & (acc_vec - 6'd1)) != 6'd0;
    assign pop       = !empty && pipe_enq__RDY;

    always_comb begin
        push_tag  = TAG_INCREMENT;
        push_data = '0;
        if (acc_vec[0]) begin
            push_tag = TAG_INCREMENT;
        end else if (acc_vec[1]) begin
            push_tag = TAG_DECREMENT;
        end else if (acc_vec[2]) begin
            push_tag = TAG_READ_GRAY;
        end else if (acc_vec[3]) begin
            push_tag  = TAG_WRITE_GRAY;
            push_data = place_arg(method_writeGray_v);
        end else if (acc_vec[4]) begin
            push_tag = TAG_READ_BIN;
        end else if (acc_vec[5]) begin
            push_tag  = TAG_WRITE_BIN;
            push_data = place_arg(method_writeBin_v);
        end
    end

    assign read_issue = push && (push_tag == TAG_READ_GRAY || push_tag == TAG_READ_BIN);

    assign pipe_enq__ENA = !empty;
    assign pipe_enq_v    = mem[rd_ptr];

    // FIFO payload storage carries no reset; occupancy tracks validity.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {push_tag, push_data};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Indications are only honoured once ready has been presented.
    assign ind_ok    = ind_enq__ENA && ind_rdy;
    assign ind_match = (ind_enq_v[143:128] == exp_tag);

    // Only the tag and the top width data bits are meaningful.
    assign ind_data_unused = ^ind_enq_v;

    assign ind_enq__RDY = ind_rdy;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state           <= S_IDLE;
            exp_tag         <= 16'd0;
            readResult      <= '0;
            readResult__RDY <= 1'b0;
            errCollision    <= 1'b0;
            errUnexpected   <= 1'b0;
            ind_rdy         <= 1'b0;
        end else begin
            ind_rdy <= 1'b1;
            if (collision) begin
                errCollision <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (read_issue) begin
                        state   <= S_WAIT;
                        exp_tag <= push_tag;
                    end
                    if (ind_ok) begin
                        errUnexpected <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ind_ok) begin
                        if (ind_match) begin
                            state           <= S_HOLD;
                            readResult      <= ind_enq_v[127 -: width];
                            readResult__RDY <= 1'b1;
                        end else begin
                            errUnexpected <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (ind_ok) begin
                        errUnexpected <= 1'b1;
                    end
                    if (resultTake__ENA) begin
                        state           <= S_IDLE;
                        readResult__RDY <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/m2p_gray_counter_ifc.md
Name: m2p_gray_counter_ifc

Overview:
- Client-side marshaller for the GrayCounterIfc request path. Accepts GrayCounterIfc method calls and serialises each one into a 144-bit NOCDataH message on an outbound PipeIn (16-bit tag + 128-bit data).
- Collects read responses from an inbound indication pipe.
- Sits between the host-side software proxy and the NoC. It is the counterpart of the pipe-to-method dispatcher on the device side.
- Contains a 2-entry outbound message FIFO and a single-outstanding-read state machine.

Parameters:
width, 4, counter width in bits; 1..128

Ports:
CLK  in  1  clock, all state on rising edge
nRST  in  1  asynchronous active-low reset
method$increment__ENA  in  1  increment call
method$increment__RDY  out  1  increment may be called
method$decrement__ENA  in  1  decrement call
method$decrement__RDY  out  1  decrement may be called
method$writeGray__ENA  in  1  writeGray call
method$writeGray$v  in  width  gray value to write
method$writeGray__RDY  out  1  writeGray may be called
method$writeBin__ENA  in  1  writeBin call
method$writeBin$v  in  width  binary value to write
method$writeBin__RDY  out  1  writeBin may be called
method$readGray__ENA  in  1  issue gray read request
method$readGray__RDY  out  1  read request may be issued
method$readBin__ENA  in  1  issue binary read request
method$readBin__RDY  out  1  read request may be issued
readResult  out  width  returned read value
readResult__RDY  out  1  readResult valid
resultTake__ENA  in  1  consume readResult
pipe$enq__ENA  out  1  outbound message valid
pipe$enq$v  out  144  outbound message {tag[15:0], data[127:0]}
pipe$enq__RDY  in  1  downstream accepts message
ind$enq__ENA  in  1  inbound indication valid
ind$enq$v  in  144  inbound indication {tag, data}
ind$enq__RDY  out  1  always 1 when out of reset
errCollision  out  1  sticky: more than one method ENA in a cycle
errUnexpected  out  1  sticky: indication dropped

Behaviour:
- Tags (bits 143:128):
  - increment = 16'd0, decrement = 1, readGray = 2, writeGray = 3, readBin = 4, writeBin = 5.
  - The argument occupies data bits [127:128-width], immediately after the tag. All other data bits are 0.
  - Argumentless methods carry data = 0.
- Reset (nRST low, asynchronous):
  - FIFO empty; FSM to IDLE; readResult = 0; readResult__RDY = 0.
  - pipe$enq__ENA = 0; errCollision = 0; errUnexpected = 0; ind$enq__RDY = 0.
  - A reset mid-read discards the outstanding request and clears all state.
- FIFO:
  - 2 entries, registered.
  - pipe$enq__ENA = !empty; pipe$enq$v = head entry.
  - The head pops on the cycle pipe$enq__ENA && pipe$enq__RDY.
  - No combinational path from method ports to pipe ports. Minimum latency from ENA to pipe$enq__ENA is 1 cycle.
- Method RDY:
  - increment/decrement/writeGray/writeBin __RDY = !full.
  - readGray__RDY = readBin__RDY = !full && state == IDLE.
  - RDY depends only on registered state; a same-cycle pop does not raise it.
- Push rules:
  - Exactly one message is pushed per accepted cycle.
  - If several ENAs are asserted together, only the lowest tag is pushed and errCollision sets.
  - An ENA while its RDY is low is ignored; nothing is pushed and no flag is set.
- Read FSM:
  - IDLE -> WAIT on an accepted readGray/readBin push. The expected tag (2 or 4) is latched.
  - WAIT -> HOLD when ind$enq__ENA arrives with tag == expected. readResult <= ind data[127:128-width]; readResult__RDY <= 1.
  - In WAIT, an indication with any other tag is dropped, errUnexpected sets, and the FSM stays in WAIT.
  - HOLD -> IDLE on resultTake__ENA; readResult__RDY <= 0, readResult keeps its value.
  - resultTake__ENA outside HOLD is ignored.
  - Any indication received in IDLE or HOLD is dropped and errUnexpected sets. In HOLD, readResult is not overwritten.
- Error flags: errCollision and errUnexpected clear only on reset.

Test Plan:
- Reset, then increment__ENA for 1 cycle with pipe$enq__RDY=1 -> next cycle pipe$enq__ENA=1, pipe$enq$v=144'h0000_<128'h0>; then the FIFO is empty.
- width=4, writeBin$v=4'hA, pipe$enq__RDY=0 -> entry {16'd5, 4'hA, 124'h0} is held; a second call fills the FIFO; all __RDY=0; a third ENA is ignored. Raise enq__RDY -> two messages drain in order.
- readGray__ENA -> tag 2 message sent; readGray__RDY=readBin__RDY=0. ind with tag 4 -> dropped, errUnexpected=1. ind with tag 2 and data[127:124]=4'h6 -> readResult=6, __RDY=1. resultTake__ENA -> IDLE.
- increment__ENA and decrement__ENA in the same cycle -> only a tag 0 message is sent; errCollision=1.
- readBin issued, nRST pulsed low in WAIT -> all outputs return to reset values asynchronously; a read request is accepted again after release.
- Back-to-back: 10 consecutive writeGray calls (values 0..9) with enq__RDY toggling 1/0 -> all 10 messages emitted in order, none lost or duplicated.
